// File: rtl/mskaes_ks_ctrl_if.sv
// Handshake and shared-data bundle between the key-schedule sequencer, its key source,
// its KS round datapath and the round-key consumer. The controller takes the slave modport.
interface mskaes_ks_ctrl_if #(
  parameter int d = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [128*d-1:0]  sh_key_in;
  logic              abort;
  logic [128*d-1:0]  sh_ks_key;
  logic [8*d-1:0]    sh_ks_rcon;
  logic [128*d-1:0]  sh_ks_res;
  logic              rnd_en;
  logic              out_valid;
  logic              out_ready;
  logic [128*d-1:0]  sh_rk_out;
  logic [3:0]        rk_idx;
  logic              busy;
  logic              done;

  modport master (
    output in_valid, sh_key_in, abort, sh_ks_res, out_ready,
    input  in_ready, sh_ks_key, sh_ks_rcon, rnd_en, out_valid, sh_rk_out, rk_idx, busy, done
  );

  modport slave (
    input  in_valid, sh_key_in, abort, sh_ks_res, out_ready,
    output in_ready, sh_ks_key, sh_ks_rcon, rnd_en, out_valid, sh_rk_out, rk_idx, busy, done
  );
endinterface

// File: rtl/mskaes_ks_ctrl.sv
// Masked AES-128 key-schedule sequencer: loads a shared key, steps the KS round datapath, streams keys 0..NROUNDS.
// Latency: a round key is offered LATENCY cycles after the previous one is accepted; done pulses in the final accept cycle.
// Backpressure: out_ready stalls only while a round key is offered; a round in flight is never stalled.
module mskaes_ks_ctrl #(
  parameter int d       = 2,
  parameter int LATENCY = 4,
  parameter int NROUNDS = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  mskaes_ks_ctrl_if.slave bus
);

  localparam int            KW       = 128*d;
  localparam int            RW       = 8*d;
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(LATENCY-1);
  localparam logic [3:0]    IDX_LAST = 4'(NROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  key_q, key_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [3:0]     idx_q, idx_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Public constant as a trivial sharing: share 0 carries the value, the rest stay zero.
  function automatic logic [RW-1:0] share_pub(input logic [7:0] v);
    logic [RW-1:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i*d] = v[i];
    end
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      rcon_q  <= '0;
      cyc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    rcon_d         = rcon_q;
    cyc_d          = cyc_q;
    idx_d          = idx_q;
    bus.in_ready   = (state_q == IDLE);
    bus.busy       = (state_q != IDLE);
    bus.out_valid  = (state_q == OUT);
    bus.rnd_en     = (state_q == RUN);
    bus.sh_ks_key  = key_q;
    bus.sh_rk_out  = key_q;
    bus.rk_idx     = idx_q;
    bus.done       = 1'b0;
    bus.sh_ks_rcon = '0;

    if (state_q == RUN && cyc_q == CYC_LAST) begin
      bus.sh_ks_rcon = share_pub(rcon_q);
    end

    // Abort wipes every share so nothing of the old key survives into IDLE.
    if (bus.abort) begin
      state_d = IDLE;
      key_d   = '0;
      rcon_d  = '0;
      cyc_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            key_d   = bus.sh_key_in;
            idx_d   = '0;
            rcon_d  = 8'h01;
            cyc_d   = '0;
            state_d = OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            if (idx_q == IDX_LAST) begin
              bus.done = 1'b1;
              state_d  = IDLE;
            end else begin
              cyc_d   = '0;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (cyc_q == CYC_LAST) begin
            key_d   = bus.sh_ks_res;
            idx_d   = idx_q + 4'd1;
            rcon_d  = xtime(rcon_q);
            cyc_d   = '0;
            state_d = OUT;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  a_run_key_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RUN && cyc_q != CYC_LAST && !bus.abort) |=> $stable(key_q));

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == OUT && !bus.out_ready && !bus.abort) |=>
      (state_q == OUT && $stable(key_q) && $stable(idx_q)));

  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n) idx_q <= IDX_LAST);

endmodule

// File: tb/tb_mskaes_ks_ctrl.sv
// Bench for mskaes_ks_ctrl: behavioural key-expansion model, a combinational KS datapath stub,
// per-cycle output comparison and directed scenarios, plus LATENCY=1 and LATENCY=6 instances.
module tb_mskaes_ks_ctrl;
  localparam int D   = 2;
  localparam int LAT = 4;
  localparam int NR  = 10;
  localparam int KW  = 128*D;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1      = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10     = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ALT_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [7:0]   RCON_TAB [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc_ctr = 0;
  int            done_seen = 0;
  logic [KW-1:0] rnd_pool = '0;
  logic [7:0]    rcon_seen [$];
  bit            start6 = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    for (int w = 0; w < KW/32; w++) begin
      rnd_pool[w*32 +: 32] <= $urandom();
    end
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, t;
    y = 8'h01; t = x;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      y = gmul(y, t);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ks_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 ^= t; w1 ^= w0; w2 ^= w1; w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] ref_rk(input logic [127:0] k, input int r);
    logic [127:0] x;
    x = k;
    for (int i = 0; i < r; i++) x = ks_round(x, RCON_TAB[i]);
    return x;
  endfunction

  function automatic logic [KW-1:0] share128(input logic [127:0] k, input logic [KW-1:0] r);
    logic [KW-1:0] s;
    logic          b;
    s = '0;
    for (int i = 0; i < 128; i++) begin
      b = k[i];
      for (int j = 1; j < D; j++) begin
        s[i*D+j] = r[i*D+j];
        b ^= r[i*D+j];
      end
      s[i*D] = b;
    end
    return s;
  endfunction

  function automatic logic [127:0] unshare128(input logic [KW-1:0] s);
    logic [127:0] k;
    k = '0;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < D; j++) k[i] ^= s[i*D+j];
    return k;
  endfunction

  function automatic logic [7:0] unshare8(input logic [8*D-1:0] s);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < D; j++) v[i] ^= s[i*D+j];
    return v;
  endfunction

  function automatic logic [8*D-1:0] spread8(input logic [7:0] v);
    logic [8*D-1:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s[i*D] = v[i];
    return s;
  endfunction

  // Datapath stand-in: result is only meaningful when the rcon sharing is presented.
  function automatic logic [KW-1:0] dp_model(input logic [KW-1:0] k, input logic [8*D-1:0] rc,
                                             input logic [KW-1:0] r);
    return share128(ks_round(unshare128(k), unshare8(rc)), r);
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- main DUT (LATENCY=4) ----------------
  mskaes_ks_ctrl_if #(.d(D)) bus();
  mskaes_ks_ctrl #(.d(D), .LATENCY(LAT), .NROUNDS(NR)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  assign bus.sh_ks_res = dp_model(bus.sh_ks_key, bus.sh_ks_rcon, rnd_pool);

  // Model: busy flag, cycles left in the current round, round index, unmasked key.
  logic         m_busy = 1'b0;
  int           m_left = 0;
  int           m_idx  = 0;
  logic [127:0] m_key  = '0;
  bit           m_zero = 1'b1;

  initial begin : compare
    logic       ev;
    logic [7:0] erc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_left = 0; m_idx = 0; m_key = '0; m_zero = 1'b1;
      end
      ev  = m_busy && (m_left == 0);
      erc = (m_busy && m_left == 1) ? RCON_TAB[m_idx] : 8'h00;
      check("in_ready", bus.in_ready, !m_busy);
      check("busy", bus.busy, m_busy);
      check("out_valid", bus.out_valid, ev);
      check("rnd_en", bus.rnd_en, m_busy && (m_left > 0));
      check("done", bus.done, ev && bus.out_ready && (m_idx == NR) && !bus.abort && rst_n);
      check("rk_idx", bus.rk_idx, m_idx);
      check("ks_rcon", bus.sh_ks_rcon, spread8(erc));
      if (m_zero) check("key_zero", bus.sh_ks_key, '0);
      else        check("ks_key", unshare128(bus.sh_ks_key), m_key);
      check("rk_out", unshare128(bus.sh_rk_out), m_key);
      if (bus.done) done_seen++;
      if (unshare8(bus.sh_ks_rcon) != 8'h00) rcon_seen.push_back(unshare8(bus.sh_ks_rcon));

      if (!rst_n) begin
      end else if (bus.abort) begin
        m_busy = 1'b0; m_left = 0; m_idx = 0; m_key = '0; m_zero = 1'b1;
      end else if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy = 1'b1; m_left = 0; m_idx = 0; m_zero = 1'b0;
          m_key  = unshare128(bus.sh_key_in);
        end
      end else if (m_left == 0) begin
        if (bus.out_ready) begin
          if (m_idx == NR) m_busy = 1'b0;
          else             m_left = LAT;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_key = ks_round(m_key, RCON_TAB[m_idx]);
          m_idx++;
        end
      end
    end
  end

  task automatic load(input logic [127:0] k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL load_wait: in_ready=%0b, expected 1 within 200 cycles", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.sh_key_in = share128(k, rnd_pool);
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.sh_key_in = '0;
  endtask

  task automatic wait_idx(input int n);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.rk_idx == 4'(n)) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idx%0d: rk_idx=%0d out_valid=%0b, expected key %0d offered within 400 cycles",
               n, bus.rk_idx, bus.out_valid, n);
    end
  endtask

  // ---------------- LATENCY=1 and LATENCY=6 builds ----------------
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : 6;
    bit fin = 1'b0;
    mskaes_ks_ctrl_if #(.d(D)) gbus();
    mskaes_ks_ctrl #(.d(D), .LATENCY(L), .NROUNDS(NR)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (gbus.slave)
    );
    assign gbus.sh_ks_res = dp_model(gbus.sh_ks_key, gbus.sh_ks_rcon, rnd_pool);

    initial begin
      int seen, last, dn;
      gbus.in_valid = 1'b0; gbus.out_ready = 1'b0; gbus.abort = 1'b0; gbus.sh_key_in = '0;
      wait (start6);
      @(posedge clk); #1;
      gbus.sh_key_in = share128(FIPS_KEY, rnd_pool);
      gbus.in_valid  = 1'b1;
      gbus.out_ready = 1'b1;
      @(posedge clk); #1;
      gbus.in_valid  = 1'b0;
      seen = 0; last = 0; dn = 0;
      for (int c = 0; c < 200 && seen <= NR; c++) begin
        @(negedge clk);
        if (gbus.done) dn++;
        if (gbus.out_valid) begin
          check($sformatf("lat%0d_idx", L), gbus.rk_idx, seen);
          check($sformatf("lat%0d_key%0d", L, seen), unshare128(gbus.sh_rk_out), ref_rk(FIPS_KEY, seen));
          if (seen > 0) check($sformatf("lat%0d_spacing", L), cyc_ctr - last, L + 1);
          last = cyc_ctr;
          seen++;
        end
      end
      check($sformatf("lat%0d_keys_seen", L), seen, NR + 1);
      check($sformatf("lat%0d_done_once", L), dn, 1);
      check($sformatf("lat%0d_final_key", L), unshare128(gbus.sh_rk_out), RK10);
      fin = 1'b1;
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int            d0, r0;
    logic [KW-1:0] snap;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.abort = 1'b0; bus.sh_key_in = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Model pins against FIPS-197 values.
    check("pin_sbox53", sbox(8'h53), 8'hed);
    check("pin_ref_rk1", ref_rk(FIPS_KEY, 1), RK1);
    check("pin_ref_rk10", ref_rk(FIPS_KEY, 10), RK10);
    check("pin_ref_alt10", ref_rk(ALT_KEY, 10), ALT_RK10);

    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_key", bus.sh_ks_key, '0);

    // 1: full schedule, no backpressure, RCON sequence.
    d0 = done_seen; r0 = rcon_seen.size();
    bus.out_ready = 1'b1;
    load(FIPS_KEY);
    wait_idx(1);
    check("t1_rk1", unshare128(bus.sh_rk_out), RK1);
    wait_idx(10);
    check("t1_rk10", unshare128(bus.sh_rk_out), RK10);
    repeat (3) @(negedge clk);
    check("t1_done_once", done_seen - d0, 1);
    check("t1_rcon_count", rcon_seen.size() - r0, 10);
    for (int i = 0; i < 10 && r0 + i < rcon_seen.size(); i++)
      check($sformatf("t1_rcon%0d", i + 1), rcon_seen[r0 + i], RCON_TAB[i]);

    // 2: hold off round key 3 for 20 cycles.
    load(FIPS_KEY);
    wait_idx(2);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    wait_idx(3);
    snap = bus.sh_rk_out;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t2_key_stable", bus.sh_rk_out, snap);
      check("t2_idx_stable", bus.rk_idx, 4'd3);
      check("t2_valid_held", bus.out_valid, 1'b1);
      check("t2_rnd_en_low", bus.rnd_en, 1'b0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_idx(4);
    check("t2_rk4", unshare128(bus.sh_rk_out), ref_rk(FIPS_KEY, 4));
    wait_idx(10);
    check("t2_rk10", unshare128(bus.sh_rk_out), RK10);

    // 4: abort in round 6 at cycle 2, then reload another key.
    d0 = done_seen;
    load(FIPS_KEY);
    wait_idx(5);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    check("t4_in_run", bus.rnd_en, 1'b1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("t4_in_ready", bus.in_ready, 1'b1);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_key_zero", bus.sh_ks_key, '0);
    check("t4_idx_zero", bus.rk_idx, 4'd0);
    check("t4_no_done", done_seen - d0, 0);
    load(ALT_KEY);
    wait_idx(10);
    check("t4_alt_rk10", unshare128(bus.sh_rk_out), ALT_RK10);
    repeat (2) @(negedge clk);
    check("t4_done_once", done_seen - d0, 1);

    // 5: asynchronous reset mid-round, then in_valid while busy.
    load(FIPS_KEY);
    wait_idx(2);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_in_ready", bus.in_ready, 1'b1);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_rnd_en", bus.rnd_en, 1'b0);
    check("t5_done", bus.done, 1'b0);
    check("t5_rk_idx", bus.rk_idx, 4'd0);
    check("t5_key", bus.sh_ks_key, '0);
    check("t5_rk_out", bus.sh_rk_out, '0);
    check("t5_rcon", bus.sh_ks_rcon, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    load(FIPS_KEY);
    repeat (3) @(posedge clk);
    #1;
    bus.sh_key_in = share128(ALT_KEY, rnd_pool);
    bus.in_valid  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.sh_key_in = '0;
    wait_idx(10);
    check("t5_rk10_unaffected", unshare128(bus.sh_rk_out), RK10);

    // 6: other LATENCY builds run the same schedule.
    start6 = 1'b1;
    for (int c = 0; c < 1000 && !(g_lat[0].fin && g_lat[1].fin); c++) @(posedge clk);
    check("t6_builds_finished", {g_lat[0].fin, g_lat[1].fin}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
